// File: rtl/sys_array_conv_k_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sys_array_conv_k_if                                                   |
// | Weight/pixel load and result strobe bundle for sys_array_conv_k.      |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
interface sys_array_conv_k_if #(
  parameter int DW = 16
);
  logic                 w_load;
  logic signed [DW-1:0] w_in;
  logic                 i_load;
  logic signed [DW-1:0] i_in;
  logic                 w_ok;
  logic                 i_ready;
  logic signed [DW-1:0] result;
  logic                 res_sig;
  logic                 frame_done;
  logic                 busy;

  modport master (
    output w_load, w_in, i_load, i_in,
    input  w_ok, i_ready, result, res_sig, frame_done, busy
  );

  modport slave (
    input  w_load, w_in, i_load, i_in,
    output w_ok, i_ready, result, res_sig, frame_done, busy
  );
endinterface
`default_nettype wire

// File: rtl/sys_array_conv_k.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sys_array_conv_k                                                      |
// | KxK weight-stationary systolic convolution over a SIZExSIZE map,      |
// | raster-order results with strobe. Macro SYS_RELU6_EN selects the      |
// | ReLU6 output clamp; otherwise the output is saturated linear.         |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module sys_array_conv_k #(
  parameter int DW    = 16,
  parameter int K     = 3,
  parameter int SIZE  = 7,
  parameter int ACC_W = 32,
  parameter int FRAC  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  sys_array_conv_k_if.slave  bus
);

  localparam int OS     = SIZE - K + 1;
  localparam int NW     = K * K;
  localparam int SR_LEN = (K - 1) * SIZE + K;
  localparam int WC_W   = $clog2(NW);
  localparam int RC_W   = $clog2(SIZE);
  localparam int RS_W   = (OS * OS > 1) ? $clog2(OS * OS) : 1;

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_wload  = 3'd1;
  localparam logic [2:0] c_st_ready  = 3'd2;
  localparam logic [2:0] c_st_stream = 3'd3;
  localparam logic [2:0] c_st_drain  = 3'd4;

  localparam logic [WC_W-1:0] c_w_last   = WC_W'(NW - 1);
  localparam logic [RC_W-1:0] c_rc_last  = RC_W'(SIZE - 1);
  localparam logic [RC_W-1:0] c_rc_win   = RC_W'(K - 1);
  localparam logic [RS_W-1:0] c_res_last = RS_W'(OS * OS - 1);

`ifdef SYS_RELU6_EN
  localparam logic signed [ACC_W-1:0] c_six = ACC_W'(6 << FRAC);
`else
  localparam logic signed [ACC_W-1:0] c_max = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] c_min = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};
`endif

  logic [2:0]              state_q, state_d;
  logic [WC_W-1:0]         w_cnt_q, w_cnt_d;
  logic signed [DW-1:0]    w_q [NW];
  logic signed [DW-1:0]    w_d [NW];
  logic                    w_ok_q, w_ok_d;
  logic [RC_W-1:0]         row_q, row_d;
  logic [RC_W-1:0]         col_q, col_d;
  logic signed [DW-1:0]    sr_q [SR_LEN];
  logic signed [DW-1:0]    sr_d [SR_LEN];
  logic                    win_vld_q, win_vld_d;
  logic signed [DW-1:0]    st_win_q [K-1][NW];
  logic signed [DW-1:0]    st_win_d [K-1][NW];
  logic signed [ACC_W-1:0] st_acc_q [K];
  logic signed [ACC_W-1:0] st_acc_d [K];
  logic [K-1:0]            st_vld_q, st_vld_d;
  logic signed [ACC_W-1:0] q_q, q_d;
  logic                    q_vld_q, q_vld_d;
  logic signed [DW-1:0]    result_q, result_d;
  logic                    res_sig_q, res_sig_d;
  logic [RS_W-1:0]         res_cnt_q, res_cnt_d;
  logic                    frame_done_q, frame_done_d;
  logic                    accept;

  // Control: weight loading, pixel acceptance, frame bookkeeping
  always_comb begin
    state_d      = state_q;
    w_cnt_d      = w_cnt_q;
    w_d          = w_q;
    w_ok_d       = w_ok_q;
    row_d        = row_q;
    col_d        = col_q;
    sr_d         = sr_q;
    win_vld_d    = 1'b0;
    res_cnt_d    = res_cnt_q;
    frame_done_d = 1'b0;
    accept       = 1'b0;

    case (state_q)
      c_st_idle, c_st_ready: begin
        if (bus.w_load) begin
          w_d[0]  = bus.w_in;
          w_cnt_d = WC_W'(1);
          w_ok_d  = 1'b0;
          state_d = c_st_wload;
        end else if (bus.i_load && (state_q == c_st_ready)) begin
          accept  = 1'b1;
          state_d = c_st_stream;
        end
      end
      c_st_wload: begin
        if (bus.w_load) begin
          w_d[w_cnt_q] = bus.w_in;
          if (w_cnt_q == c_w_last) begin
            w_cnt_d = '0;
            w_ok_d  = 1'b1;
            state_d = c_st_ready;
          end else begin
            w_cnt_d = w_cnt_q + WC_W'(1);
          end
        end
      end
      c_st_stream: begin
        if (bus.i_load) begin
          accept = 1'b1;
          if ((row_q == c_rc_last) && (col_q == c_rc_last)) begin
            state_d = c_st_drain;
          end
        end
      end
      c_st_drain: begin
        if (res_sig_q && (res_cnt_q == c_res_last)) begin
          frame_done_d = 1'b1;
          state_d      = c_st_ready;
        end
      end
      default: state_d = c_st_idle;
    endcase

    // Line buffer: newest pixel at index 0, so the KxK window sits in fixed taps
    if (accept) begin
      sr_d[0] = bus.i_in;
      for (int i = 1; i < SR_LEN; i++) begin
        sr_d[i] = sr_q[i-1];
      end
      win_vld_d = (row_q >= c_rc_win) && (col_q >= c_rc_win);
      if (col_q == c_rc_last) begin
        col_d = '0;
        row_d = (row_q == c_rc_last) ? '0 : row_q + RC_W'(1);
      end else begin
        col_d = col_q + RC_W'(1);
      end
    end

    if (res_sig_q) begin
      res_cnt_d = (res_cnt_q == c_res_last) ? '0 : res_cnt_q + RS_W'(1);
    end
  end

  // Systolic row stages: stage k adds kernel row k against the window it carries
  always_comb begin
    int                      idx;
    logic signed [DW-1:0]    px;
    logic signed [2*DW-1:0]  prod;
    logic signed [ACC_W-1:0] rsum;
    st_win_d = st_win_q;
    st_acc_d = st_acc_q;
    idx      = 0;
    px       = '0;
    prod     = '0;
    rsum     = '0;

    for (int k = 0; k < K - 1; k++) begin
      idx = (k == 0) ? 0 : k - 1;
      for (int x = 0; x < NW; x++) begin
        if (k == 0) begin
          st_win_d[k][x] = sr_q[(K-1-x/K)*SIZE + (K-1-x%K)];
        end else begin
          st_win_d[k][x] = st_win_q[idx][x];
        end
      end
    end

    for (int k = 0; k < K; k++) begin
      idx  = (k == 0) ? 0 : k - 1;
      rsum = '0;
      for (int j = 0; j < K; j++) begin
        if (k == 0) begin
          px = sr_q[(K-1)*SIZE + (K-1-j)];
        end else begin
          px = st_win_q[idx][k*K + j];
        end
        prod = w_q[k*K + j] * px;
        rsum = rsum + ACC_W'(prod);
      end
      if (k == 0) begin
        st_acc_d[k] = rsum;
      end else begin
        st_acc_d[k] = st_acc_q[idx] + rsum;
      end
    end
  end

  assign st_vld_d = {st_vld_q[K-2:0], win_vld_q};
  assign q_d      = st_acc_q[K-1] >>> FRAC;
  assign q_vld_d  = st_vld_q[K-1];

  always_comb begin
    result_d  = result_q;
    res_sig_d = q_vld_q;
    if (q_vld_q) begin
`ifdef SYS_RELU6_EN
      if (q_q[ACC_W-1]) begin
        result_d = '0;
      end else if (q_q > c_six) begin
        result_d = c_six[DW-1:0];
      end else begin
        result_d = q_q[DW-1:0];
      end
`else
      if (q_q > c_max) begin
        result_d = c_max[DW-1:0];
      end else if (q_q < c_min) begin
        result_d = c_min[DW-1:0];
      end else begin
        result_d = q_q[DW-1:0];
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= c_st_idle;
      w_cnt_q      <= '0;
      w_ok_q       <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      win_vld_q    <= 1'b0;
      st_vld_q     <= '0;
      q_q          <= '0;
      q_vld_q      <= 1'b0;
      result_q     <= '0;
      res_sig_q    <= 1'b0;
      res_cnt_q    <= '0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < NW; i++) begin
        w_q[i] <= '0;
      end
      for (int i = 0; i < SR_LEN; i++) begin
        sr_q[i] <= '0;
      end
      for (int k = 0; k < K - 1; k++) begin
        for (int x = 0; x < NW; x++) begin
          st_win_q[k][x] <= '0;
        end
      end
      for (int k = 0; k < K; k++) begin
        st_acc_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      w_cnt_q      <= w_cnt_d;
      w_q          <= w_d;
      w_ok_q       <= w_ok_d;
      row_q        <= row_d;
      col_q        <= col_d;
      sr_q         <= sr_d;
      win_vld_q    <= win_vld_d;
      st_win_q     <= st_win_d;
      st_acc_q     <= st_acc_d;
      st_vld_q     <= st_vld_d;
      q_q          <= q_d;
      q_vld_q      <= q_vld_d;
      result_q     <= result_d;
      res_sig_q    <= res_sig_d;
      res_cnt_q    <= res_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.w_ok       = w_ok_q;
  assign bus.i_ready    = (state_q == c_st_ready) || (state_q == c_st_stream);
  assign bus.busy       = (state_q == c_st_stream) || (state_q == c_st_drain);
  assign bus.result     = result_q;
  assign bus.res_sig    = res_sig_q;
  assign bus.frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_sys_array_conv_k.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_sys_array_conv_k                                                   |
// | Directed + randomized frames against a 2-D convolution model.         |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_sys_array_conv_k;
  localparam int DW    = 16;
  localparam int K     = 3;
  localparam int SIZE  = 7;
  localparam int ACC_W = 32;
  localparam int FRAC  = 8;
  localparam int OS    = SIZE - K + 1;
  localparam int NP    = SIZE * SIZE;
  localparam int NW    = K * K;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   wt [NW];
  int   img [NP];
  int   acc_c [NP];
  int   res_v [$];
  int   res_c [$];
  int   fd_c [$];

  sys_array_conv_k_if #(.DW(DW)) bus ();

  sys_array_conv_k #(
    .DW(DW), .K(K), .SIZE(SIZE), .ACC_W(ACC_W), .FRAC(FRAC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.res_sig === 1'b1) begin
      res_v.push_back(int'(bus.result));
      res_c.push_back(cyc);
    end
    if (bus.frame_done === 1'b1) fd_c.push_back(cyc);
  end

  // Reference: plain 2-D valid convolution, shift, then the output activation
  function automatic int exp_res(input int r, input int c);
    longint acc = 0;
    longint q;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        acc += longint'(wt[i*K + j]) * longint'(img[(r+i)*SIZE + c + j]);
    q = acc >>> FRAC;
`ifdef SYS_RELU6_EN
    if (q < 0) return 0;
    if (q > (6 << FRAC)) return 6 << FRAC;
    return int'(q);
`else
    if (q > 32767) return 32767;
    if (q < -32768) return -32768;
    return int'(q);
`endif
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load_weights(input int start);
    for (int k = start; k < NW; k++) begin
      bus.w_load = 1'b1;
      bus.w_in   = DW'(wt[k]);
      @(posedge clk); #1;
      bus.w_load = 1'b0;
      if (k == 0) chk("w_ok_clr", bus.w_ok, 0);
      repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
    end
    chk("w_ok", bus.w_ok, 1);
  endtask

  task automatic run_frame(input int gap_mode, input bit wjunk);
    int n;
    res_v.delete(); res_c.delete(); fd_c.delete();
    for (int p = 0; p < NP; p++) begin
      chk("i_ready", bus.i_ready, 1);
      bus.i_load = 1'b1;
      bus.i_in   = DW'(img[p]);
      bus.w_load = wjunk && (p % 5 == 2);
      bus.w_in   = DW'($urandom);
      @(posedge clk); #1;
      acc_c[p]   = cyc;
      bus.i_load = 1'b0;
      bus.w_load = 1'b0;
      if (gap_mode == 1) begin
        @(posedge clk); #1;
      end else if (gap_mode == 2) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
    end
    for (int t = 0; t < 200 && fd_c.size() == 0; t++) @(posedge clk);
    #1;
    chk("fd_seen", fd_c.size(), 1);
    chk("n_res", res_v.size(), OS*OS);
    n = (res_v.size() < OS*OS) ? res_v.size() : OS*OS;
    for (int i = 0; i < n; i++) begin
      int r = i / OS;
      int c = i % OS;
      chk("res_val", res_v[i], exp_res(r, c));
      chk("res_cyc", res_c[i], acc_c[(r+K-1)*SIZE + c + K - 1] + K + 2);
    end
    if (fd_c.size() > 0 && res_c.size() > 0) chk("fd_cyc", fd_c[0], res_c[res_c.size()-1] + 1);
    chk("busy_end", bus.busy, 0);
    chk("ready_end", bus.i_ready, 1);
  endtask

  task automatic rand_weights();
    for (int k = 0; k < NW; k++) wt[k] = int'($urandom_range(0, 1024)) - 512;
  endtask

  task automatic rand_image();
    for (int p = 0; p < NP; p++) img[p] = int'($urandom_range(0, 1024)) - 512;
  endtask

  initial begin
    bus.w_load = 1'b0; bus.w_in = '0; bus.i_load = 1'b0; bus.i_in = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_result", bus.result, 0);
    chk("rst_res_sig", bus.res_sig, 0);
    chk("rst_fd", bus.frame_done, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_w_ok", bus.w_ok, 0);
    chk("rst_i_ready", bus.i_ready, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready", bus.i_ready, 0);

    // Identity kernel
    for (int k = 0; k < NW; k++) wt[k] = (k == NW/2) ? 256 : 0;
    for (int p = 0; p < NP; p++) img[p] = p;
    load_weights(0);
    run_frame(0, 1'b0);
    chk("id_first", res_v.size() > 0 ? res_v[0] : -1, 8);
    chk("id_last", res_v.size() > 0 ? res_v[res_v.size()-1] : -1, 40);
    chk("id_lat", res_c.size() > 0 ? res_c[0] - acc_c[16] : -1, 5);

    // Saturation, then back-to-back reuse of the same weights
    for (int k = 0; k < NW; k++) wt[k] = 256;
    for (int p = 0; p < NP; p++) img[p] = 128;
    load_weights(0);
    run_frame(0, 1'b0);
    for (int p = 0; p < NP; p++) img[p] = 256;
    run_frame(0, 1'b0);

    // Negative sums
    for (int k = 0; k < NW; k++) wt[k] = -256;
    load_weights(0);
    run_frame(0, 1'b0);

    // Random data: toggled gaps, then random gaps with ignored w_load
    rand_weights();
    rand_image();
    load_weights(0);
    run_frame(1, 1'b0);
    run_frame(2, 1'b1);

    // w_load and i_load together in READY: reload wins, pixel dropped
    rand_weights();
    rand_image();
    bus.w_load = 1'b1; bus.w_in = DW'(wt[0]);
    bus.i_load = 1'b1; bus.i_in = DW'(12345);
    @(posedge clk); #1;
    bus.w_load = 1'b0; bus.i_load = 1'b0;
    chk("prio_w_ok", bus.w_ok, 0);
    chk("prio_busy", bus.busy, 0);
    chk("prio_ready", bus.i_ready, 0);
    load_weights(1);
    run_frame(2, 1'b0);

    // Reset mid-frame at pixel 20
    rand_image();
    for (int p = 0; p < 20; p++) begin
      bus.i_load = 1'b1; bus.i_in = DW'(img[p]);
      @(posedge clk); #1;
    end
    bus.i_in = DW'(img[20]);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_result", bus.result, 0);
    chk("mr_res_sig", bus.res_sig, 0);
    chk("mr_fd", bus.frame_done, 0);
    chk("mr_busy", bus.busy, 0);
    chk("mr_w_ok", bus.w_ok, 0);
    chk("mr_i_ready", bus.i_ready, 0);
    res_v.delete(); res_c.delete(); fd_c.delete();
    bus.i_load = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int t = 0; t < 10; t++) begin
      bus.i_load = 1'b1; bus.i_in = DW'(img[t]);
      @(posedge clk); #1;
    end
    bus.i_load = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mr_nostrobe", res_v.size(), 0);
    chk("mr_nofd", fd_c.size(), 0);
    chk("mr_idle_busy", bus.busy, 0);
    load_weights(0);
    run_frame(0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, observed no end expected end");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
